// File: rtl/mag_pkg.sv
// Shared types and defaults for the magnitude pipeline (magnitude stage,
// window statistics and the chip output mux).
package mag_pkg;

  localparam int MAG_W         = 8;
  localparam int DEF_LOG2_WIN  = 4;
  localparam int DEF_ALARM_CNT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } mag_state_e;

endpackage

// File: rtl/mag_minmax_track.sv
// Running max/min register pair. The next-state values are exported so the
// caller can latch a result that already includes the current sample.
module mag_minmax_track
  import mag_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             update,
  input  logic [MAG_W-1:0] sample,
  output logic [MAG_W-1:0] max_q,
  output logic [MAG_W-1:0] min_q,
  output logic [MAG_W-1:0] max_d,
  output logic [MAG_W-1:0] min_d
);

  always_comb begin
    max_d = max_q;
    min_d = min_q;
    if (load) begin
      max_d = sample;
      min_d = sample;
    end else if (update) begin
      max_d = (sample > max_q) ? sample : max_q;
      min_d = (sample < min_q) ? sample : min_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_q <= '0;
      min_q <= '0;
    end else begin
      max_q <= max_d;
      min_q <= min_d;
    end
  end

endmodule

// File: rtl/mag_window_stats.sv
// Per-window peak/min/average/exceed-count statistics over non-overlapping
// windows of 2^LOG2_WIN accepted magnitude samples, plus a sticky alarm.
module mag_window_stats
  import mag_pkg::*;
#(
  parameter int LOG2_WIN  = DEF_LOG2_WIN,
  parameter int ALARM_CNT = DEF_ALARM_CNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MAG_W-1:0] mag_in,
  input  logic             mag_valid,
  input  logic [MAG_W-1:0] threshold,
  input  logic             clear,
  output logic [MAG_W-1:0] peak_out,
  output logic [MAG_W-1:0] min_out,
  output logic [MAG_W-1:0] avg_out,
  output logic [MAG_W-1:0] above_out,
  output logic             win_done,
  output logic             alarm
);

  localparam int SUM_W   = MAG_W + LOG2_WIN;
  localparam int CNT_W   = LOG2_WIN;
  localparam int ABOVE_W = LOG2_WIN + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = '1;

  mag_state_e         state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d, sum_next;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ABOVE_W-1:0] run_above_q, run_above_d, above_next;
  logic [MAG_W-1:0]   peak_q, peak_d, min_out_q, min_out_d;
  logic [MAG_W-1:0]   avg_q, avg_d, above_out_q, above_out_d;
  logic               win_done_q, win_done_d, alarm_q, alarm_d;
  logic               mm_load, mm_update, hit;
  logic [8:0]         above_ext;
  logic [MAG_W-1:0]   above_sat;
  logic [MAG_W-1:0]   run_max_q, run_min_q, run_max_d, run_min_d;

  mag_minmax_track u_minmax (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (mm_load),
    .update (mm_update),
    .sample (mag_in),
    .max_q  (run_max_q),
    .min_q  (run_min_q),
    .max_d  (run_max_d),
    .min_d  (run_min_d)
  );

  always_comb begin
    hit         = (mag_in >= threshold);
    sum_next    = sum_q + SUM_W'(mag_in);
    above_next  = run_above_q + ABOVE_W'(hit);
    above_ext   = 9'(above_next);
    above_sat   = (above_ext > 9'd255) ? 8'hFF : above_ext[7:0];
    state_d     = state_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    run_above_d = run_above_q;
    peak_d      = peak_q;
    min_out_d   = min_out_q;
    avg_d       = avg_q;
    above_out_d = above_out_q;
    win_done_d  = 1'b0;
    alarm_d     = alarm_q;
    mm_load     = 1'b0;
    mm_update   = 1'b0;
    if (clear) begin
      state_d     = IDLE;
      sum_d       = '0;
      cnt_d       = '0;
      run_above_d = '0;
      alarm_d     = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (mag_valid) begin
            mm_update = 1'b1;
            // Closing sample: latch results including it and restart the window
            if (cnt_q == LAST_CNT) begin
              peak_d      = run_max_d;
              min_out_d   = run_min_d;
              avg_d       = MAG_W'(sum_next >> LOG2_WIN);
              above_out_d = above_sat;
              win_done_d  = 1'b1;
              if (int'(above_sat) >= ALARM_CNT) alarm_d = 1'b1;
              sum_d       = '0;
              cnt_d       = '0;
              run_above_d = '0;
              state_d     = DONE;
            end else begin
              sum_d       = sum_next;
              cnt_d       = cnt_q + CNT_W'(1);
              run_above_d = above_next;
            end
          end
        end
        default: begin
          if (mag_valid) begin
            mm_load     = 1'b1;
            sum_d       = SUM_W'(mag_in);
            cnt_d       = CNT_W'(1);
            run_above_d = ABOVE_W'(hit);
            state_d     = ACC;
          end else begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      cnt_q       <= '0;
      run_above_q <= '0;
      peak_q      <= '0;
      min_out_q   <= '0;
      avg_q       <= '0;
      above_out_q <= '0;
      win_done_q  <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      run_above_q <= run_above_d;
      peak_q      <= peak_d;
      min_out_q   <= min_out_d;
      avg_q       <= avg_d;
      above_out_q <= above_out_d;
      win_done_q  <= win_done_d;
      alarm_q     <= alarm_d;
    end
  end

  assign peak_out  = peak_q;
  assign min_out   = min_out_q;
  assign avg_out   = avg_q;
  assign above_out = above_out_q;
  assign win_done  = win_done_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_mag_window_stats.sv
// Scoreboard bench for mag_window_stats: a reference model pushes expected
// window results as samples are driven; a monitor pops them on win_done.
module tb_mag_window_stats;

  localparam int WIN       = 16;
  localparam int ALARM_CNT = 8;

  typedef struct {
    int peak;
    int minv;
    int avg;
    int above;
    int alarm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] mag_in;
  logic       mag_valid;
  logic [7:0] threshold;
  logic       clear;
  logic [7:0] peak_out, min_out, avg_out, above_out;
  logic       win_done, alarm;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t last_exp;
  int   pulses[$];
  logic prev_wd = 1'b0;

  int m_cnt = 0, m_sum = 0, m_max = 0, m_min = 0, m_above = 0, m_alarm = 0;

  mag_window_stats #(.LOG2_WIN(4), .ALARM_CNT(ALARM_CNT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mag_in    (mag_in),
    .mag_valid (mag_valid),
    .threshold (threshold),
    .clear     (clear),
    .peak_out  (peak_out),
    .min_out   (min_out),
    .avg_out   (avg_out),
    .above_out (above_out),
    .win_done  (win_done),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model step for one accepted sample
  task automatic modelSample(input int v, input int t);
    exp_t e;
    if (m_cnt == 0) begin
      m_sum = v; m_max = v; m_min = v; m_above = (v >= t) ? 1 : 0;
    end else begin
      m_sum += v;
      if (v > m_max) m_max = v;
      if (v < m_min) m_min = v;
      if (v >= t) m_above++;
    end
    m_cnt++;
    if (m_cnt == WIN) begin
      if (m_above >= ALARM_CNT) m_alarm = 1;
      e.peak  = m_max;
      e.minv  = m_min;
      e.avg   = m_sum / WIN;
      e.above = (m_above > 255) ? 255 : m_above;
      e.alarm = m_alarm;
      sb.push_back(e);
      last_exp = e;
      m_cnt = 0;
    end
  endtask

  task automatic applyStimulus(input logic v, input int m, input int t, input logic c);
    mag_valid = v;
    mag_in    = 8'(m);
    threshold = 8'(t);
    clear     = c;
    @(posedge clk);
    if (c) begin
      m_cnt = 0;
      m_alarm = 0;
    end else if (v) begin
      modelSample(m, t);
    end
    #1;
    mag_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic idle(input int n);
    mag_valid = 1'b0;
    clear     = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drainCheck(input string tag);
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
    idle(2);
    checkOutput(tag, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && win_done) begin
      pulses.push_back(cyc);
      if (prev_wd) checkOutput("win_done_width", 2, 1);
      if (sb.size() == 0) begin
        checkOutput("unexpected_win_done", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("peak", int'(peak_out), e.peak);
        checkOutput("min", int'(min_out), e.minv);
        checkOutput("avg", int'(avg_out), e.avg);
        checkOutput("above", int'(above_out), e.above);
        checkOutput("alarm", int'(alarm), e.alarm);
      end
    end
    prev_wd = rst_n && win_done;
  end

  initial begin
    rst_n = 1'b0; mag_in = '0; mag_valid = 1'b0; threshold = '0; clear = 1'b0;
    idle(2);
    checkOutput("rst_peak", int'(peak_out), 0);
    checkOutput("rst_win_done", int'(win_done), 0);
    checkOutput("rst_alarm", int'(alarm), 0);
    rst_n = 1'b1;

    // Constant 10 below threshold
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 10, 11, 1'b0);
    drainCheck("t1_sb_empty");

    // Ramp with random gaps, then an all-zero window: alarm stays sticky
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      applyStimulus(1'b1, i, 8, 1'b0);
    end
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 0, 8, 1'b0);
    drainCheck("t2_sb_empty");
    checkOutput("t2_alarm_sticky", int'(alarm), 1);

    // Full-scale samples, no sum overflow
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 255, 255, 1'b0);
    drainCheck("t3_sb_empty");

    // Partial window discarded by clear (sample with clear dropped)
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 100, 255, 1'b0);
    applyStimulus(1'b1, 100, 255, 1'b1);
    checkOutput("t4_alarm_cleared", int'(alarm), 0);
    checkOutput("t4_peak_held", int'(peak_out), last_exp.peak);
    checkOutput("t4_avg_held", int'(avg_out), last_exp.avg);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 20, 255, 1'b0);
    drainCheck("t4_sb_empty");

    // Clear on the window-closing sample: no latch, no pulse
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 77, 0, 1'b0);
    applyStimulus(1'b1, 77, 0, 1'b1);
    idle(2);
    checkOutput("t4b_no_latch_avg", int'(avg_out), last_exp.avg);
    checkOutput("t4b_sb_empty", sb.size(), 0);

    // Continuous stream of three windows
    pulses.delete();
    for (int w = 1; w <= 3; w++)
      for (int i = 0; i < 16; i++) begin
        mag_valid = 1'b1; mag_in = 8'(w); threshold = 8'd2; clear = 1'b0;
        @(posedge clk);
        modelSample(w, 2);
        #1;
      end
    mag_valid = 1'b0;
    drainCheck("t5_sb_empty");
    checkOutput("t5_pulse_count", pulses.size(), 3);
    if (pulses.size() == 3) begin
      checkOutput("t5_spacing_a", pulses[1] - pulses[0], 16);
      checkOutput("t5_spacing_b", pulses[2] - pulses[1], 16);
    end

    // Reset mid-window
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 50, 0, 1'b0);
    rst_n = 1'b0;
    idle(1);
    m_cnt = 0; m_alarm = 0;
    checkOutput("t6_rst_avg", int'(avg_out), 0);
    checkOutput("t6_rst_peak", int'(peak_out), 0);
    checkOutput("t6_rst_alarm", int'(alarm), 0);
    rst_n = 1'b1;
    idle(1);
    checkOutput("t6_post_min", int'(min_out), 0);
    checkOutput("t6_post_above", int'(above_out), 0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 30, 0, 1'b0);
    drainCheck("t6_sb_empty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mag_window_stats.md
Name: mag_window_stats

Overview:
- Downstream consumer of the vector-magnitude stage. Accepts a stream of 8-bit magnitude samples qualified by a valid strobe.
- Over fixed non-overlapping windows of 2^LOG2_WIN samples, it produces these per-window statistics: peak, minimum, floor average and threshold-exceed count.
- Also maintains a sticky alarm. Results feed the chip output mux.

Parameters:
- LOG2_WIN, 4, log2 of the window length in accepted samples (window = 16 by default); legal range 1..8.
- ALARM_CNT, 8, the alarm sets when a completed window's exceed count is >= this value.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mag_in  in  8  magnitude sample (unsigned).
- mag_valid  in  1  mag_in is sampled on a rising clk edge when this is high. There is no backpressure; every valid sample is accepted.
- threshold  in  8  exceed threshold (unsigned). Sampled together with each accepted sample.
- clear  in  1  synchronous clear of the window in progress and of the alarm.
- peak_out  out  8  max of the last completed window.
- min_out  out  8  min of the last completed window.
- avg_out  out  8  floor(sum / 2^LOG2_WIN) of the last completed window.
- above_out  out  8  count of samples >= threshold in the last completed window. Saturates at 255.
- win_done  out  1  one-cycle pulse: the outputs above were just updated.
- alarm  out  1  sticky alarm.

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0, accumulators cleared, FSM returns to IDLE. A reset mid-window discards the partial window.
- Internal state:
  - sum register, 8+LOG2_WIN bits wide. It cannot overflow: 2^LOG2_WIN*255 fits.
  - cnt register, LOG2_WIN bits wide.
  - run_max, run_min and run_above registers.
- FSM states are IDLE, ACC and DONE.
  - IDLE: no samples in the window. An accepted sample loads run_max = run_min = mag_in, sum = mag_in, run_above = (mag_in >= threshold), cnt = 1, then moves to ACC.
  - ACC: an accepted sample updates sum += mag_in, run_max = max, run_min = min and run_above += (mag_in >= threshold), and increments cnt.
    - If this sample is the last of the window (cnt == 2^LOG2_WIN-1 before the update), the outputs latch at the same edge from the values including this sample. Then win_done = 1 for the next cycle only, state goes to DONE and the accumulators are re-initialised.
  - DONE: lasts exactly one cycle; win_done is high during it. An accepted sample in DONE is treated exactly as in IDLE and becomes the first sample of the new window. With no sample, the FSM goes to IDLE.
  - When LOG2_WIN = 1 the window closes every 2nd sample. Back-to-back windows must work with mag_valid held high continuously, so DONE overlaps the first sample of the next window.
- Timing:
  - Latency from the edge that accepts the last sample of a window to the updated outputs and win_done: 1 cycle (registered outputs visible after that edge).
  - Outputs hold their values between windows.
- Alarm:
  - Set at the window-close edge if the new above_out >= ALARM_CNT.
  - Stays set across later windows until clear or reset.
- clear:
  - Returns the FSM to IDLE, discards the partial window, drops alarm to 0 and forces win_done to 0.
  - Does not change peak_out, min_out, avg_out or above_out.
  - clear and mag_valid in the same cycle: clear wins and the sample is dropped.
  - clear on the same edge as a window-closing sample: clear wins; no latch, no win_done.
  - Precedence: rst_n low over clear, clear over mag_valid.
- Gaps in mag_valid are allowed anywhere; only accepted samples count.
- Comparisons are unsigned. mag_in == threshold counts as an exceed.

Decomposition:
- Shared package mag_pkg:
  - FSM state enum: IDLE, ACC, DONE.
  - MAG_W = 8.
  - Default LOG2_WIN and ALARM_CNT constants, shared with the upstream magnitude stage and the top-level output mux.
- One sub-module is natural: mag_minmax_track, a running max/min register pair with load/update/hold controls, instantiated once.

Test Plan:
- 16 consecutive valid samples of 10, threshold 11 -> after the last edge: peak 10, min 10, avg 10, above 0, win_done high for exactly 1 cycle, alarm 0.
- Ramp 0..15 with random valid gaps, threshold 8 -> sum 120, avg 7, peak 15, min 0, above 8, alarm 1 (ALARM_CNT=8). The alarm remains 1 after a following window of all-zero samples.
- 16 samples of 255, threshold 255 -> avg 255, above 16, no overflow.
- 5 samples of 100, then clear together with a valid 100, then 16 samples of 20 -> the single win_done reports avg 20, peak 20, min 20; alarm 0 after clear.
- Continuous mag_valid for 48 samples (three windows of constant values 1, 2, 3) -> three win_done pulses 16 cycles apart, avg 1, 2, 3 in order; no sample lost at the DONE overlap.
- rst_n low for 1 cycle after 9 samples of 50, then 16 samples of 30 -> all outputs read 0 during and immediately after reset; the first window reports avg 30, peak 30, min 30.
